// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and defaults for the round-robin mux-select arbiter.
// Optional hold timeout is enabled with MUX_SEL_ARB_TIMEOUT_EN.
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF  = 8;
    localparam int SEL_W_DEF    = 3;
    localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between requesters and the mux-select arbiter.
// Requesters drive req; the arbiter drives grant, sel and busy.
interface mux_sel_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int SEL_W   = SEL_W_DEF
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               busy;

    modport master (
        output req,
        input  grant,
        input  sel,
        input  busy
    );

    modport slave (
        input  req,
        output grant,
        output sel,
        output busy
    );

endinterface

// File: rtl/mux_sel_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first unmasked request after last.
// Scan order is last+1 upward, wrapping, with last itself checked last.
module rr_priority_picker
    import mux_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    input  logic [NUM_REQ-1:0] excl,
    output logic               valid,
    output logic [SEL_W-1:0]   win
);

    logic [NUM_REQ-1:0] cand;
    logic [SEL_W:0]     sum;
    logic [SEL_W-1:0]   pos;

    always_comb begin
        cand  = req & ~excl;
        valid = 1'b0;
        win   = '0;
        sum   = '0;
        pos   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(NUM_REQ))
                sum = sum - (SEL_W+1)'(NUM_REQ);
            pos = sum[SEL_W-1:0];
            if (!valid && cand[pos]) begin
                valid = 1'b1;
                win   = pos;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter owning the shared 8:1 mux select; grants are sticky.
// Define MUX_SEL_ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int SEL_W    = SEL_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mux_sel_arbiter_if.slave  bus
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (2**SEL_W) < NUM_REQ
        || MAX_HOLD < 2) begin : g_bad_cfg
        $error("mux_sel_arbiter: illegal parameter set");
    end

    arb_state_e         state;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic [SEL_W-1:0]   last;

    logic               owner_req;
    logic               hold_expired;
    logic [NUM_REQ-1:0] excl;
    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;

    assign owner_req = bus.req[sel];
    assign pick_oh   = NUM_REQ'(1) << pick_idx;

`ifdef MUX_SEL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] cnt;

    assign hold_expired = (state == OWNED) && owner_req
                          && (cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    // On timeout the owner is masked so any waiting requester wins.
    assign excl = hold_expired ? (NUM_REQ'(1) << sel) : '0;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req   (bus.req),
        .last  (last),
        .excl  (excl),
        .valid (pick_valid),
        .win   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            last  <= SEL_W'(NUM_REQ - 1);
`ifdef MUX_SEL_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= OWNED;
                        grant <= pick_oh;
                        sel   <= pick_idx;
                        busy  <= 1'b1;
                        last  <= pick_idx;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                OWNED: begin
                    if (owner_req && !hold_expired) begin
`ifdef MUX_SEL_ARB_TIMEOUT_EN
                        cnt <= cnt + 1'b1;
`endif
                    end else if (pick_valid) begin
                        // Handover without an idle bubble.
                        grant <= pick_oh;
                        sel   <= pick_idx;
                        last  <= pick_idx;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end else if (owner_req) begin
`ifdef MUX_SEL_ARB_TIMEOUT_EN
                        cnt <= '0;
`endif
                    end else begin
                        // sel holds so the mux output stays stable.
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant = grant;
    assign bus.sel   = sel;
    assign bus.busy  = busy;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed self-checking bench for mux_sel_arbiter.
// Timeout expectations follow MUX_SEL_ARB_TIMEOUT_EN with MAX_HOLD = 4.
module tb_mux_sel_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_sel_arbiter_if #(.NUM_REQ(8), .SEL_W(3)) bus ();

    mux_sel_arbiter #(
        .NUM_REQ  (8),
        .SEL_W    (3),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] g,
                           input logic [2:0] s, input logic b);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".sel"},   32'(bus.sel),   32'(s));
        chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    endtask

    initial begin
        logic [7:0] drop;
        checks = 0;
        errors = 0;

        rst = 1'b1;
        bus.req = 8'hFF;
        step();
        chk_all("reset0", 8'h00, 3'd0, 1'b0);
        step();
        chk_all("reset1", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("first", 8'h01, 3'd0, 1'b1);

        bus.req = 8'h00;
        step();
        chk_all("release0", 8'h00, 3'd0, 1'b0);

        bus.req = 8'h04;
        step();
        chk_all("single", 8'h04, 3'd2, 1'b1);
        step();
        step();
        step();
        step();
        chk_all("single_hold", 8'h04, 3'd2, 1'b1);
        bus.req = 8'h00;
        step();
        chk_all("single_drop", 8'h00, 3'd2, 1'b0);
        step();
        chk_all("idle_hold", 8'h00, 3'd2, 1'b0);

        rst = 1'b1;
        bus.req = 8'hFF;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("rr_sel%0d", i), 32'(bus.sel), 32'(i % 8));
            chk($sformatf("rr_oh%0d", i), 32'($onehot(bus.grant)), 32'd1);
            chk($sformatf("rr_busy%0d", i), 32'(bus.busy), 32'd1);
            drop = 8'h01 << (i % 8);
            bus.req = 8'hFF & ~drop;
            step();
        end

        bus.req = 8'h22;
        step();
        chk_all("gap_own", 8'h02, 3'd1, 1'b1);
        bus.req = 8'h20;
        step();
        chk_all("gapless", 8'h20, 3'd5, 1'b1);

        bus.req = 8'h00;
        step();
        chk_all("gap_idle", 8'h00, 3'd5, 1'b0);
        bus.req = 8'h08;
        step();
        chk_all("mid_own", 8'h08, 3'd3, 1'b1);
        rst = 1'b1;
        step();
        chk_all("mid_rst", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("mid_regrant", 8'h08, 3'd3, 1'b1);

        bus.req = 8'h03;
        step();
        chk_all("to_start", 8'h01, 3'd0, 1'b1);
        for (int k = 1; k < 13; k++) begin
            step();
`ifdef MUX_SEL_ARB_TIMEOUT_EN
            chk($sformatf("to_sel%0d", k), 32'(bus.sel), 32'((k / 4) % 2));
`else
            chk($sformatf("to_sel%0d", k), 32'(bus.sel), 32'd0);
`endif
            chk($sformatf("to_busy%0d", k), 32'(bus.busy), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
